line_follow_ctrl: RTL and testbench

- Motion controller that sequences the car's two wheel drivers from the 3-bit line-tracker state.
- Debounces the tracker state and maps it to per-wheel duty and direction.
- On line loss, runs a recovery sequence: hold last steer, then spin-search toward the last known side, then halt.
- Sits between the tracker-sensor block and the PWM motor drivers.

---
 rtl/line_follow_pkg.sv | 55 +++++
 rtl/line_follow_ctrl_debounce.sv | 49 ++++
 rtl/line_follow_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_line_follow_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/line_follow_pkg.sv
// rtl/line_follow_pkg.sv - shared tracker codes, FSM states and drive types for the line follower
// Purpose: definitions shared by track_debounce, line_follow_ctrl and the tracker-sensor block.
// Ports: none (package).
package line_follow_pkg;

    localparam int SPD_W = 10;

    // Tracker codes, as produced by the tracker-sensor block
    localparam logic [2:0] TRK_TURN_LEFT   = 3'b000;
    localparam logic [2:0] TRK_TURN_RIGHT  = 3'b001;
    localparam logic [2:0] TRK_STRAIGHT    = 3'b010;
    localparam logic [2:0] TRK_LOST        = 3'b011;
    localparam logic [2:0] TRK_SHARP_LEFT  = 3'b100;
    localparam logic [2:0] TRK_SHARP_RIGHT = 3'b101;

    // FSM states; the encoding is visible on the mode output
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_FOLLOW = 3'b001,
        ST_HOLD   = 3'b010,
        ST_SEARCH = 3'b011,
        ST_HALT   = 3'b100
    } fsm_state_t;

    typedef struct packed {
        logic [SPD_W-1:0] spd;
        logic             dir;   // 1 = forward
    } wheel_t;

    typedef struct packed {
        wheel_t l;
        wheel_t r;
    } drive_t;

    // Unused codes 110/111 behave as go_straight
    function automatic logic [2:0] normalize_code(input logic [2:0] code);
        if (code == 3'b110 || code == 3'b111) begin
            return TRK_STRAIGHT;
        end
        return code;
    endfunction

    // Move cur toward tgt by at most step, landing exactly on tgt
    function automatic logic [SPD_W-1:0] slew(input logic [SPD_W-1:0] cur,
                                              input logic [SPD_W-1:0] tgt,
                                              input logic [SPD_W-1:0] step);
        if (cur < tgt) begin
            return ((tgt - cur) > step) ? cur + step : tgt;
        end else if (cur > tgt) begin
            return ((cur - tgt) > step) ? cur - step : tgt;
        end
        return cur;
    endfunction

endpackage

// File: rtl/line_follow_ctrl_debounce.sv
// rtl/line_follow_ctrl_debounce.sv - tracker state debouncer (module track_debounce)
// Purpose: accept a raw tracker code only after DEBOUNCE identical consecutive samples.
// Ports: clk, reset (sync, active-high); track_state raw code in;
//        stable_state accepted code out; update pulses on each cycle a code is accepted.
// DEBOUNCE must be at least 2.
import line_follow_pkg::*;

module track_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] track_state,
    output logic [2:0] stable_state,
    output logic       update
);

    localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] CNT_ARM  = CW'(DEBOUNCE - 2);

    logic [2:0]    prev_raw;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_raw     <= TRK_LOST;
            count        <= '0;
            stable_state <= TRK_LOST;
            update       <= 1'b0;
        end else begin
            prev_raw <= track_state;
            update   <= 1'b0;
            if (track_state != prev_raw) begin
                count <= '0;
            end else begin
                if (count != CNT_LAST) begin
                    count <= count + 1'b1;
                end
                // The count lands on DEBOUNCE-1 now, or is already saturated there
                if (count == CNT_ARM || count == CNT_LAST) begin
                    stable_state <= normalize_code(track_state);
                    update       <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/line_follow_ctrl.sv
// rtl/line_follow_ctrl.sv - line-follower motion controller (top)
// Purpose: debounce tracker state, steer the two wheels, recover on line loss (hold, search, halt).
// Ports: clk, reset (sync, active-high); enable run request; track_state raw tracker code;
//        left_speed/right_speed 10-bit duty; left_dir/right_dir (1 = forward); mode FSM state.
// Option: SPEED_RAMP_EN slews speed outputs by RAMP_STEP per cycle, ramping through 0 on reversal.
import line_follow_pkg::*;

module line_follow_ctrl #(
    parameter int DEBOUNCE       = 4,
    parameter int LOST_HOLD      = 1000,
    parameter int SEARCH_TIMEOUT = 50000,
    parameter int SPD_FAST       = 700,
    parameter int SPD_SLOW       = 400,
    parameter int SPD_SEARCH     = 500,
    parameter int RAMP_STEP      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       track_state,
    output logic [SPD_W-1:0] left_speed,
    output logic [SPD_W-1:0] right_speed,
    output logic             left_dir,
    output logic             right_dir,
    output logic [2:0]       mode
);

`ifdef SPEED_RAMP_EN
    localparam logic             RAMP_ON = 1'b1;
    localparam logic [SPD_W-1:0] STEP    = SPD_W'(RAMP_STEP);
`else
    // Full-scale step: every slew lands on its target in a single cycle
    localparam logic             RAMP_ON = 1'b0;
    localparam logic [SPD_W-1:0] STEP    = {SPD_W{1'b1}} | SPD_W'(RAMP_STEP);
`endif

    localparam int PH_MAX = (LOST_HOLD > SEARCH_TIMEOUT) ? LOST_HOLD : SEARCH_TIMEOUT;
    localparam int PW     = (PH_MAX > 2) ? $clog2(PH_MAX) : 1;
    localparam logic [PW-1:0] HOLD_LAST   = PW'(LOST_HOLD - 1);
    localparam logic [PW-1:0] SEARCH_LAST = PW'(SEARCH_TIMEOUT - 1);

    localparam logic [SPD_W-1:0] FAST   = SPD_W'(SPD_FAST);
    localparam logic [SPD_W-1:0] SLOW   = SPD_W'(SPD_SLOW);
    localparam logic [SPD_W-1:0] SEARCH = SPD_W'(SPD_SEARCH);

    localparam drive_t DRIVE_STOP = '{l: '{spd: '0, dir: 1'b1}, r: '{spd: '0, dir: 1'b1}};

    logic [2:0]    stable_state;
    logic          stable_update;
    fsm_state_t    state;
    logic [PW-1:0] phase;
    logic          last_side;     // 0 = line last seen on the left
    drive_t        tgt;
    wheel_t        left_w;
    wheel_t        right_w;
    logic          line_lost;

    track_debounce #(
        .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
        .clk         (clk),
        .reset       (reset),
        .track_state (track_state),
        .stable_state(stable_state),
        .update      (stable_update)
    );

    assign line_lost = (stable_state == TRK_LOST);

    function automatic drive_t follow_targets(input logic [2:0] code);
        drive_t d;
        d.l.spd = FAST;
        d.l.dir = 1'b1;
        d.r.spd = FAST;
        d.r.dir = 1'b1;
        case (code)
            TRK_TURN_LEFT:   d.l.spd = SLOW;
            TRK_TURN_RIGHT:  d.r.spd = SLOW;
            TRK_SHARP_LEFT: begin
                d.l.spd = SLOW;
                d.l.dir = 1'b0;
            end
            TRK_SHARP_RIGHT: begin
                d.r.spd = SLOW;
                d.r.dir = 1'b0;
            end
            default: ;
        endcase
        return d;
    endfunction

    // Spin in place toward the side the line was last seen on
    function automatic drive_t search_targets(input logic side);
        drive_t d;
        d.l.spd = SEARCH;
        d.r.spd = SEARCH;
        d.l.dir = side;
        d.r.dir = ~side;
        return d;
    endfunction

    // A wheel never flips direction while moving when ramping is enabled
    function automatic wheel_t wheel_step(input wheel_t cur, input wheel_t want);
        wheel_t nxt;
        nxt = cur;
        if (RAMP_ON && (cur.dir != want.dir)) begin
            if (cur.spd == '0) begin
                nxt.dir = want.dir;
            end else begin
                nxt.spd = slew(cur.spd, '0, STEP);
            end
        end else begin
            nxt.dir = want.dir;
            nxt.spd = slew(cur.spd, want.spd, STEP);
        end
        return nxt;
    endfunction

    // State, phase counter and targets are registered together, so the
    // targets always describe the state being entered or held.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            phase     <= '0;
            last_side <= 1'b0;
            tgt       <= DRIVE_STOP;
        end else begin
            if (stable_update) begin
                case (stable_state)
                    TRK_TURN_LEFT,  TRK_SHARP_LEFT:  last_side <= 1'b0;
                    TRK_TURN_RIGHT, TRK_SHARP_RIGHT: last_side <= 1'b1;
                    default: ;
                endcase
            end

            if (!enable) begin
                state <= ST_IDLE;
                phase <= '0;
                tgt   <= DRIVE_STOP;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!line_lost) begin
                            state <= ST_FOLLOW;
                            phase <= '0;
                            tgt   <= follow_targets(stable_state);
                        end else begin
                            tgt <= DRIVE_STOP;
                        end
                    end
                    ST_FOLLOW: begin
                        if (line_lost) begin
                            // Keep steering as last commanded while the line is briefly gone
                            state <= ST_HOLD;
                            phase <= '0;
                        end else begin
                            tgt <= follow_targets(stable_state);
                        end
                    end
                    ST_HOLD: begin
                        if (!line_lost) begin
                            state <= ST_FOLLOW;
                            phase <= '0;
                            tgt   <= follow_targets(stable_state);
                        end else if (phase == HOLD_LAST) begin
                            state <= ST_SEARCH;
                            phase <= '0;
                            tgt   <= search_targets(last_side);
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                    ST_SEARCH: begin
                        if (!line_lost) begin
                            state <= ST_FOLLOW;
                            phase <= '0;
                            tgt   <= follow_targets(stable_state);
                        end else if (phase == SEARCH_LAST) begin
                            state <= ST_HALT;
                            phase <= '0;
                            tgt   <= DRIVE_STOP;
                        end else begin
                            phase <= phase + 1'b1;
                            tgt   <= search_targets(last_side);
                        end
                    end
                    ST_HALT: begin
                        // Only dropping enable leaves HALT
                        tgt <= DRIVE_STOP;
                    end
                    default: begin
                        state <= ST_IDLE;
                        phase <= '0;
                        tgt   <= DRIVE_STOP;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            left_w  <= DRIVE_STOP.l;
            right_w <= DRIVE_STOP.r;
            mode    <= ST_IDLE;
        end else begin
            left_w  <= wheel_step(left_w, tgt.l);
            right_w <= wheel_step(right_w, tgt.r);
            mode    <= state;
        end
    end

    assign left_speed  = left_w.spd;
    assign left_dir    = left_w.dir;
    assign right_speed = right_w.spd;
    assign right_dir   = right_w.dir;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// tb/tb_line_follow_ctrl.sv - scoreboard testbench for line_follow_ctrl
module tb_line_follow_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] track_state;
    logic [9:0] left_speed;
    logic [9:0] right_speed;
    logic       left_dir;
    logic       right_dir;
    logic [2:0] mode;

    line_follow_ctrl #(
        .DEBOUNCE      (2),
        .LOST_HOLD     (5),
        .SEARCH_TIMEOUT(10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .track_state(track_state),
        .left_speed (left_speed),
        .right_speed(right_speed),
        .left_dir   (left_dir),
        .right_dir  (right_dir),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    when;
        string name;
        int    l;
        int    r;
        int    ld;
        int    rd;
        int    m;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    bit   finishing = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int off, input string nm, input int l, input int r,
                             input int ld, input int rd, input int m);
        exp_t e;
        int   i;
        e.when = cyc + off;
        e.name = nm;
        e.l    = l;
        e.r    = r;
        e.ld   = ld;
        e.rd   = rd;
        e.m    = m;
        i = 0;
        while (i < sb.size() && sb[i].when <= e.when) i++;
        sb.insert(i, e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops every expectation due this cycle and compares the outputs
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && (sb[0].when <= cyc || finishing)) begin
            e = sb.pop_front();
            n_checks++;
            if (e.when != cyc) begin
                n_fail++;
                $display("FAIL %s: check due at cycle %0d handled at cycle %0d", e.name, e.when, cyc);
            end else if ({left_speed, right_speed, left_dir, right_dir, mode} !==
                         {10'(e.l), 10'(e.r), 1'(e.ld), 1'(e.rd), 3'(e.m)}) begin
                n_fail++;
                $display("FAIL %s @%0d: got l=%0d r=%0d ld=%0b rd=%0b mode=%0d, want l=%0d r=%0d ld=%0d rd=%0d mode=%0d",
                         e.name, cyc, left_speed, right_speed, left_dir, right_dir, mode,
                         e.l, e.r, e.ld, e.rd, e.m);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        track_state = 3'b011;
        expect_at(2, "reset", 0, 0, 1, 1, 0);
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(1);

`ifdef SPEED_RAMP_EN
        enable      = 1'b1;
        track_state = 3'b010;
        expect_at(4,   "ramp_up_1",   8,   8,   1, 1, 1);
        expect_at(5,   "ramp_up_2",   16,  16,  1, 1, 1);
        expect_at(100, "ramp_up_top", 700, 700, 1, 1, 1);
        wait_cyc(100);
        track_state = 3'b101;
        expect_at(4,   "ramp_down_1",   700, 692, 1, 1, 1);
        expect_at(91,  "ramp_at_zero",  700, 0,   1, 1, 1);
        expect_at(92,  "ramp_dir_flip", 700, 0,   1, 0, 1);
        expect_at(93,  "ramp_rev_1",    700, 8,   1, 0, 1);
        expect_at(142, "ramp_rev_top",  700, 400, 1, 0, 1);
        wait_cyc(145);
`else
        // Enable with straight: FOLLOW at full speed
        enable      = 1'b1;
        track_state = 3'b010;
        expect_at(3, "t1_still_idle", 0,   0,   1, 1, 0);
        expect_at(4, "t1_follow",     700, 700, 1, 1, 1);
        wait_cyc(6);

        // One-cycle glitch must not be accepted
        track_state = 3'b000;
        expect_at(2, "t2_glitch_a", 700, 700, 1, 1, 1);
        expect_at(4, "t2_glitch_b", 700, 700, 1, 1, 1);
        expect_at(6, "t2_glitch_c", 700, 700, 1, 1, 1);
        wait_cyc(1);
        track_state = 3'b010;
        wait_cyc(6);

        // Sharp left, then line lost: HOLD 5, SEARCH 10, HALT
        track_state = 3'b100;
        expect_at(4, "t3_sharp_left", 400, 700, 0, 1, 1);
        wait_cyc(6);
        track_state = 3'b011;
        expect_at(3, "t3_pre_hold", 400, 700, 0, 1, 1);
        for (int i = 4; i <= 8; i++) expect_at(i, "t3_hold", 400, 700, 0, 1, 2);
        for (int i = 9; i <= 18; i++) expect_at(i, "t3_search_left", 500, 500, 0, 1, 3);
        expect_at(19, "t3_halt", 0, 0, 1, 1, 4);
        wait_cyc(20);
        track_state = 3'b010;
        expect_at(5, "t3_halt_sticky", 0, 0, 1, 1, 4);
        wait_cyc(6);

        // Leave HALT via enable; re-enable while lost stays IDLE
        enable      = 1'b0;
        track_state = 3'b011;
        expect_at(1, "t5a_halt_last", 0, 0, 1, 1, 4);
        expect_at(2, "t5a_idle",      0, 0, 1, 1, 0);
        wait_cyc(4);
        enable = 1'b1;
        expect_at(2, "t5b_stay_idle_a", 0, 0, 1, 1, 0);
        expect_at(4, "t5b_stay_idle_b", 0, 0, 1, 1, 0);
        wait_cyc(6);

        // Turn right, lose line (search right), reacquire with turn_right
        track_state = 3'b001;
        expect_at(4, "t4_turn_right", 700, 400, 1, 1, 1);
        wait_cyc(6);
        track_state = 3'b011;
        expect_at(9, "t4_search_right", 500, 500, 1, 0, 3);
        wait_cyc(10);
        track_state = 3'b001;
        expect_at(3, "t4_search_before", 500, 500, 1, 0, 3);
        expect_at(4, "t4_reacquire",     700, 400, 1, 1, 1);
        wait_cyc(6);

        // Drop enable mid-SEARCH, then re-enable while lost
        track_state = 3'b011;
        expect_at(9, "t5_search", 500, 500, 1, 0, 3);
        wait_cyc(10);
        enable = 1'b0;
        expect_at(1, "t5_search_last", 500, 500, 1, 0, 3);
        expect_at(2, "t5_idle",        0,   0,   1, 1, 0);
        wait_cyc(3);
        enable = 1'b1;
        expect_at(3, "t5_reenable_lost", 0, 0, 1, 1, 0);
        wait_cyc(5);

        // Code 110 is straight; turn_left; last_side back to left
        track_state = 3'b110;
        expect_at(4, "t6_code110", 700, 700, 1, 1, 1);
        wait_cyc(6);
        track_state = 3'b000;
        expect_at(4, "t6_turn_left", 400, 700, 1, 1, 1);
        wait_cyc(6);
        track_state = 3'b011;
        expect_at(9, "t6_search_left", 500, 500, 0, 1, 3);
        wait_cyc(10);
`endif

        wait_cyc(2);
        finishing = 1'b1;
        wait_cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
